// File: rtl/round_pkg.sv
// round_pkg: shared types and constants for the round timer controller.
//   round_state_e : round FSM state encoding (PAUSED only reachable when
//                   ROUND_PAUSE_EN is defined)
//   bcd_digit_t   : one BCD digit
//   BCD_NINE      : largest BCD digit value
//   SCORE_MAX     : saturation value of a two-digit BCD counter (99)
package round_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    OVER   = 2'd2,
    PAUSED = 2'd3
  } round_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE  = 4'd9;
  localparam logic [7:0] SCORE_MAX = 8'h99;

endpackage

// File: rtl/bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD register.
//   clk, rst_n : clock, asynchronous active-low reset (resets to INIT value)
//   load       : load INIT_TENS/INIT_ONES (highest priority)
//   inc        : increment, saturating at 99
//   dec        : decrement, stopping at 00
//   tens, ones : current BCD digits
module bcd_digit_pair
  import round_pkg::*;
#(
  parameter bcd_digit_t INIT_TENS = '0,
  parameter bcd_digit_t INIT_ONES = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  output bcd_digit_t tens,
  output bcd_digit_t ones
);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      tens_d = INIT_TENS;
      ones_d = INIT_ONES;
    end else if (inc) begin
      if ({tens_q, ones_q} != SCORE_MAX) begin
        if (ones_q == BCD_NINE) begin
          ones_d = '0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end else if (dec) begin
      if ((tens_q != '0) || (ones_q != '0)) begin
        if (ones_q == '0) begin
          ones_d = BCD_NINE;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= INIT_TENS;
      ones_q <= INIT_ONES;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: game-round controller. Runs the IDLE/PLAY/OVER round
// FSM, counts the remaining round time down in BCD once per SecondTick and
// keeps a saturating BCD hit score.
//   ClockIn, ResetN      : clock, asynchronous active-low reset
//   SecondTick           : one-cycle pulse per second
//   Start                : synchronized key level, rising edge starts a round
//   Hit                  : one-cycle pulse per successful whack
//   Pause                : pause request level (used only with ROUND_PAUSE_EN)
//   TimeTens/TimeOnes    : BCD seconds remaining
//   ScoreTens/ScoreOnes  : BCD score
//   Playing/GameOver     : state decodes for PLAY/OVER
//   RoundDone            : one-cycle pulse on entry to OVER
// Build option: define ROUND_PAUSE_EN to enable the PAUSED state.
module round_timer_ctrl
  import round_pkg::*;
#(
  parameter int unsigned ROUND_SECONDS = 60
) (
  input  logic       ClockIn,
  input  logic       ResetN,
  input  logic       SecondTick,
  input  logic       Start,
  input  logic       Hit,
  input  logic       Pause,
  output logic [3:0] TimeOnes,
  output logic [3:0] TimeTens,
  output logic [3:0] ScoreOnes,
  output logic [3:0] ScoreTens,
  output logic       Playing,
  output logic       GameOver,
  output logic       RoundDone
);

  localparam bcd_digit_t RS_TENS = bcd_digit_t'(ROUND_SECONDS / 10);
  localparam bcd_digit_t RS_ONES = bcd_digit_t'(ROUND_SECONDS % 10);

  round_state_e state_q, state_d;
  logic         start_q, start_d;
  logic         round_done_q, round_done_d;
  logic         start_rise;
  logic         time_load, time_dec, score_clr, score_inc;
  logic         time_is_one;

`ifndef ROUND_PAUSE_EN
  logic unused_pause;
  assign unused_pause = Pause;
`endif

  assign start_rise  = Start & ~start_q;
  assign start_d     = Start;
  assign time_is_one = (TimeTens == 4'd0) && (TimeOnes == 4'd1);

  always_comb begin
    state_d      = state_q;
    round_done_d = 1'b0;
    time_load    = 1'b0;
    time_dec     = 1'b0;
    score_clr    = 1'b0;
    score_inc    = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d   = PLAY;
          time_load = 1'b1;
          score_clr = 1'b1;
        end
      end
      PLAY: begin
        score_inc = Hit;
        time_dec  = SecondTick;
        // The final tick ends the round even if a pause is requested on
        // the same cycle.
        if (SecondTick && time_is_one) begin
          state_d      = OVER;
          round_done_d = 1'b1;
        end
`ifdef ROUND_PAUSE_EN
        else if (Pause) begin
          state_d = PAUSED;
        end
`endif
      end
`ifdef ROUND_PAUSE_EN
      PAUSED: begin
        if (!Pause) state_d = PLAY;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      start_q      <= 1'b1;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      round_done_q <= round_done_d;
    end
  end

  bcd_digit_pair #(
    .INIT_TENS (RS_TENS),
    .INIT_ONES (RS_ONES)
  ) u_time (
    .clk   (ClockIn),
    .rst_n (ResetN),
    .load  (time_load),
    .inc   (1'b0),
    .dec   (time_dec),
    .tens  (TimeTens),
    .ones  (TimeOnes)
  );

  bcd_digit_pair #(
    .INIT_TENS ('0),
    .INIT_ONES ('0)
  ) u_score (
    .clk   (ClockIn),
    .rst_n (ResetN),
    .load  (score_clr),
    .inc   (score_inc),
    .dec   (1'b0),
    .tens  (ScoreTens),
    .ones  (ScoreOnes)
  );

  assign Playing   = (state_q == PLAY);
  assign GameOver  = (state_q == OVER);
  assign RoundDone = round_done_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
module tb_round_timer_ctrl;

  logic       ClockIn = 1'b0;
  logic       ResetN = 1'b0;
  logic       SecondTick = 1'b0;
  logic       Start = 1'b1;
  logic       Hit = 1'b0;
  logic       Pause = 1'b0;
  logic [3:0] TimeOnes, TimeTens, ScoreOnes, ScoreTens;
  logic       Playing, GameOver, RoundDone;

  always #5 ClockIn = ~ClockIn;

  round_timer_ctrl #(.ROUND_SECONDS(60)) dut (
    .ClockIn    (ClockIn),
    .ResetN     (ResetN),
    .SecondTick (SecondTick),
    .Start      (Start),
    .Hit        (Hit),
    .Pause      (Pause),
    .TimeOnes   (TimeOnes),
    .TimeTens   (TimeTens),
    .ScoreOnes  (ScoreOnes),
    .ScoreTens  (ScoreTens),
    .Playing    (Playing),
    .GameOver   (GameOver),
    .RoundDone  (RoundDone)
  );

  typedef struct {
    string      tag;
    logic [3:0] tt, to, st, so;
    logic       pl, go, rd;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  string      cur_tag = "reset";
  logic [3:0] e_tt = 4'd6, e_to = 4'd0, e_st = 4'd0, e_so = 4'd0;
  logic       e_pl = 1'b0, e_go = 1'b0, e_rd = 1'b0;
  int         tnow;

  task automatic set_time(input int v);
    e_tt = 4'(v / 10);
    e_to = 4'(v % 10);
  endtask

  task automatic set_score(input int v);
    e_st = 4'(v / 10);
    e_so = 4'(v % 10);
  endtask

  task automatic set_flags(input logic pl, input logic go, input logic rd);
    e_pl = pl;
    e_go = go;
    e_rd = rd;
  endtask

  // Drive one cycle of inputs; the expectation is what the outputs must
  // show after the following rising edge.
  task automatic cyc(input logic rn, input logic tk, input logic ht,
                     input logic st, input logic ps);
    exp_t e;
    @(negedge ClockIn);
    ResetN = rn; SecondTick = tk; Hit = ht; Start = st; Pause = ps;
    e.tag = cur_tag;
    e.tt = e_tt; e.to = e_to; e.st = e_st; e.so = e_so;
    e.pl = e_pl; e.go = e_go; e.rd = e_rd;
    sb_q.push_back(e);
    @(posedge ClockIn);
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h at %0t", tag, fld, got, want, $time);
    end
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge ClockIn);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "TimeTens",  TimeTens,        e.tt);
        chk(e.tag, "TimeOnes",  TimeOnes,        e.to);
        chk(e.tag, "ScoreTens", ScoreTens,       e.st);
        chk(e.tag, "ScoreOnes", ScoreOnes,       e.so);
        chk(e.tag, "Playing",   {3'b0, Playing},   {3'b0, e.pl});
        chk(e.tag, "GameOver",  {3'b0, GameOver},  {3'b0, e.go});
        chk(e.tag, "RoundDone", {3'b0, RoundDone}, {3'b0, e.rd});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired, pending=%0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with Start held: no round may start on release.
    cur_tag = "reset";
    set_time(60); set_score(0); set_flags(0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cur_tag = "held_start_after_reset";
    cyc(1, 0, 0, 1, 0);
    cur_tag = "idle_tick_hit";
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);

    // Round 1: reach time 37 with score 5, then reset mid-round.
    cur_tag = "start1";
    set_flags(1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cur_tag = "hits1";
    for (int k = 1; k <= 5; k++) begin set_score(k); cyc(1, 0, 1, 1, 0); end
    cur_tag = "ticks1";
    for (int i = 1; i <= 23; i++) begin set_time(60 - i); cyc(1, 1, 0, 1, 0); end
    cur_tag = "mid_reset";
    set_time(60); set_score(0); set_flags(0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);

    // Round 2: 25 hits, then a full 60-tick countdown.
    cur_tag = "start2";
    set_flags(1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cur_tag = "hits2";
    for (int k = 1; k <= 25; k++) begin set_score(k); cyc(1, 0, 1, 0, 0); end
    cur_tag = "countdown";
    for (int i = 1; i <= 60; i++) begin
      set_time(60 - i);
      if (i == 60) set_flags(0, 1, 1);
      cyc(1, 1, 0, 0, 0);
    end
    cur_tag = "tick61_in_over";
    set_flags(0, 1, 0);
    cyc(1, 1, 1, 0, 0);

    // Restart from OVER with Start held for 10 cycles.
    cur_tag = "restart";
    set_time(60); set_score(0); set_flags(1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cur_tag = "start_held";
    tnow = 60;
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) set_score(1);
      if (c == 5) begin tnow = 59; set_time(tnow); end
      cyc(1, (c == 5), (c == 3), 1, 0);
    end
`ifndef ROUND_PAUSE_EN
    cur_tag = "pause_ignored";
    tnow = 58; set_time(tnow);
    cyc(1, 1, 0, 0, 1);
`endif

    // Score saturation.
    cur_tag = "saturate";
    for (int j = 1; j <= 104; j++) begin
      set_score((1 + j > 99) ? 99 : 1 + j);
      cyc(1, 0, 1, 0, 0);
    end
    cur_tag = "finish_round";
    while (tnow > 0) begin
      tnow--;
      set_time(tnow);
      if (tnow == 0) set_flags(0, 1, 1);
      cyc(1, 1, 0, 0, 0);
    end
    set_flags(0, 1, 0);
    cyc(1, 0, 0, 0, 0);

    // Round 3: hit coincides with the final tick at score 41.
    cur_tag = "start3";
    set_time(60); set_score(0); set_flags(1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    for (int k = 1; k <= 41; k++) begin set_score(k); cyc(1, 0, 1, 0, 0); end
    for (int i = 1; i <= 59; i++) begin set_time(60 - i); cyc(1, 1, 0, 0, 0); end
    cur_tag = "hit_final_tick";
    set_time(0); set_score(42); set_flags(0, 1, 1);
    cyc(1, 1, 1, 0, 0);
    set_flags(0, 1, 0);
    cyc(1, 0, 0, 0, 0);

    // Round 4: tick held high for 3 cycles decrements 3 times.
    cur_tag = "start4";
    set_time(60); set_score(0); set_flags(1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cur_tag = "wide_tick";
    for (int i = 1; i <= 3; i++) begin set_time(60 - i); cyc(1, 1, 0, 0, 0); end
`ifdef ROUND_PAUSE_EN
    for (int i = 4; i <= 30; i++) begin set_time(60 - i); cyc(1, 1, 0, 0, 0); end
    cur_tag = "pause";
    set_flags(0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    for (int c = 0; c < 8; c++) cyc(1, (c < 5), (c >= 5), (c == 6), 1);
    cur_tag = "unpause";
    set_flags(1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    set_time(29);
    cyc(1, 1, 0, 0, 0);
`endif

    @(negedge ClockIn);
    SecondTick = 1'b0; Hit = 1'b0; Start = 1'b0; Pause = 1'b0;
    repeat (4) @(posedge ClockIn);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_timer_ctrl.md
# round_timer_ctrl

Game-round controller sitting directly downstream of the one-second rate divider and upstream of the seven-segment hex decoders. Consumes the single-cycle once-per-second tick and player inputs. Runs the IDLE/PLAY/OVER round state machine and counts the remaining round time down in BCD. Keeps a saturating BCD hit score, and drives the time and score digit nibbles straight into the hex decoders.

## Interface
- ROUND_SECONDS, 60: round length in seconds, legal 1..99; split at elaboration into BCD tens = ROUND_SECONDS/10, ones = ROUND_SECONDS%10.
- ClockIn  input  1  system clock (CLOCK_50 at top level).
- ResetN  input  1  asynchronous, active-low reset.
- SecondTick  input  1  one-cycle pulse per second from the rate divider.
- Start  input  1  level from a synchronized key; block detects its rising edge internally.
- Hit  input  1  one-cycle pulse per successful whack.
- Pause  input  1  level, pause request; only used when ROUND_PAUSE_EN is defined, otherwise ignored.
- TimeOnes  output  4  BCD ones digit of seconds remaining.
- TimeTens  output  4  BCD tens digit of seconds remaining.
- ScoreOnes  output  4  BCD ones digit of score.
- ScoreTens  output  4  BCD tens digit of score.
- Playing  output  1  high while state is PLAY.
- GameOver  output  1  high while state is OVER.
- RoundDone  output  1  one-cycle pulse on entry to OVER.

## Operation
- States: IDLE, PLAY, OVER; PAUSED only with ROUND_PAUSE_EN.
- Start edge:
  - StartRise = Start & ~StartQ, where StartQ is the registered previous Start.
  - StartQ resets to 1, so a key already held during reset does not start a round.
- IDLE:
  - Time holds the ROUND_SECONDS value; ticks and hits are ignored.
  - StartRise → PLAY, score cleared, time reloaded.
- PLAY, on SecondTick:
  - Time decrements in BCD: ones 0 → ones 9 and tens−1; otherwise ones−1.
  - If time is 01 at the tick: time becomes 00, the state moves to OVER and RoundDone pulses, all on the same edge.
- PLAY, on Hit:
  - Score increments in BCD: ones 9 → ones 0 and tens+1.
  - Score saturates at 99; further hits leave it at 99.
- PLAY, StartRise is ignored (no mid-round restart).
- OVER:
  - Time holds 00 and score is frozen; ticks and hits are ignored.
  - StartRise → PLAY with time reloaded and score cleared, both on the same edge.
- Simultaneous events:
  - Hit together with the final tick: the hit is counted, because the score update is qualified by the current state PLAY.
  - StartRise together with a tick in IDLE/OVER: start wins and time loads to full; that tick is not applied.
- Reset mid-round:
  - Immediately returns to IDLE with time = ROUND_SECONDS, score 00 and all flags 0.
  - No RoundDone is pulsed.
- The time digits never leave 0..9 and the tens digit never underflows: decrement is only possible from ≥01.

## Timing
- All outputs are registered; every input affects the outputs one ClockIn edge later.
- Reset values:
  - TimeTens/TimeOnes = ROUND_SECONDS in BCD (default 6/0).
  - ScoreTens/ScoreOnes = 0/0.
  - Playing = 0, GameOver = 0, RoundDone = 0, StartQ = 1.
- Playing and GameOver are decoded from the state register: mutually exclusive, no glitches.
- RoundDone is high for exactly one cycle per round end.
- SecondTick must be at most one cycle wide; a tick held high for N cycles decrements N times.
- A round spans ROUND_SECONDS ticks: with ROUND_SECONDS = 60, the 60th tick after StartRise ends the round.

## Configuration
- ROUND_PAUSE_EN defined:
  - PLAY with Pause=1 → PAUSED on the next edge.
  - In PAUSED, ticks, hits and StartRise are ignored; Playing = 0 and GameOver = 0.
  - Pause=0 → PLAY; time and score resume unchanged.
  - Pause in IDLE/OVER has no effect.
- ROUND_PAUSE_EN undefined: the Pause port exists but is unused, and there is no PAUSED state.

## Structure
- Shared package (round_pkg):
  - State enum with encodings IDLE=2'd0, PLAY=2'd1, OVER=2'd2, PAUSED=2'd3.
  - BCD digit typedef (4 bits).
  - Constants BCD_NINE=4'd9 and SCORE_MAX=8'h99.
- One sub-module: bcd_digit_pair.
  - A two-digit BCD register with load, increment-saturate-at-99 and decrement-stop-at-00 controls.
  - Instantiated twice: once for time (load/decrement) and once for score (clear/increment).

## Test plan
- Reset asserted mid-round at time 37 → next sample: time 60, score 00, Playing 0, GameOver 0, RoundDone never pulsed.
- Start rise, then 60 ticks with ROUND_SECONDS=60 → time 59…10, 09…00 in sequence. The 60th tick sets GameOver=1 with one-cycle RoundDone, and a 61st tick leaves time at 00.
- In PLAY, 105 Hit pulses → score reads 99 after the 99th hit and stays 99.
- Hit and final tick (time 01) in the same cycle with score 41 → score 42, time 00, GameOver=1.
- In OVER with score 25, Start rise → next edge: PLAY, time 60, score 00. Start held for 10 cycles gives only one restart; ticks in IDLE leave time at 60.
- With ROUND_PAUSE_EN: Pause at time 30 for 5 ticks and 3 hits → time 30 and score unchanged, Playing 0. On release, the next tick gives 29.
